// File: rtl/alu_mips_if.sv
// Operand/opcode bus and registered result bus of the MIPS datapath ALU.
interface alu_mips_if;
    logic [1:0]  in_op_type_1;
    logic [1:0]  in_op_type_2;
    logic        in_op_type_3;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic [31:0] out_result;
    logic        out_slt;

    modport master (
        output in_op_type_1, in_op_type_2, in_op_type_3, in_1, in_2,
        input  out_result, out_slt
    );

    modport slave (
        input  in_op_type_1, in_op_type_2, in_op_type_3, in_1, in_2,
        output out_result, out_slt
    );
endinterface

// File: rtl/alu_mips.sv
// Registered 32-bit ALU: logic, add/sub, signed SLT and shift/rotate,
// one cycle from operands to result.
module alu_mips (
    input  logic    clk,
    input  logic    reset,
    alu_mips_if.slave bus
);
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [4:0]  w_n;
    logic [5:0]  w_inv_n;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;
    logic [31:0] w_rol;
    logic [31:0] w_ror;
    logic [31:0] w_shift;
    logic        w_lt;
    logic [31:0] w_result;
    logic        w_slt;
    logic [31:0] r_result;
    logic        r_slt;

    assign w_a     = bus.in_1;
    assign w_b     = bus.in_2;
    assign w_n     = w_b[4:0];
    assign w_inv_n = 6'd32 - {1'b0, w_n};

    // A shift by 32 yields zero, so n=0 rotates return A unchanged.
    assign w_sll = w_a << w_n;
    assign w_srl = w_a >> w_n;
    assign w_sra = $unsigned($signed(w_a) >>> w_n);
    assign w_rol = w_sll | (w_a >> w_inv_n);
    assign w_ror = w_srl | (w_a << w_inv_n);
    assign w_lt  = $signed(w_b) < $signed(w_a);

    always_comb begin
        w_shift = bus.in_op_type_3 ? w_srl : w_sll;
        unique case (bus.in_op_type_2)
            2'b01:   w_shift = bus.in_op_type_3 ? w_ror : w_rol;
            2'b10:   w_shift = bus.in_op_type_3 ? w_sra : w_sll;
            default: w_shift = bus.in_op_type_3 ? w_srl : w_sll;
        endcase
    end

    always_comb begin
        w_result = 32'h0;
        w_slt    = 1'b0;
        unique case (bus.in_op_type_1)
            2'b11: begin
                unique case (bus.in_op_type_2)
                    2'b00:   w_result = w_a & w_b;
                    2'b01:   w_result = w_a | w_b;
                    2'b10:   w_result = ~(w_a | w_b);
                    default: w_result = w_a ^ w_b;
                endcase
            end
            2'b10: begin
                w_result = bus.in_op_type_2[0] ? (w_a - w_b) : (w_a + w_b);
            end
            2'b01: begin
                w_slt    = w_lt;
                w_result = {31'b0, w_lt};
            end
            default: w_result = w_shift;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= 32'h0;
            r_slt    <= 1'b0;
        end else begin
            r_result <= w_result;
            r_slt    <= w_slt;
        end
    end

    assign bus.out_result = r_result;
    assign bus.out_slt    = r_slt;
endmodule

// File: tb/tb_alu_mips.sv
// Directed self-checking bench for alu_mips.
module tb_alu_mips;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    alu_mips_if bus ();

    alu_mips dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] o1, input logic [1:0] o2,
                         input logic o3, input logic [31:0] a,
                         input logic [31:0] b);
        bus.in_op_type_1 = o1;
        bus.in_op_type_2 = o2;
        bus.in_op_type_3 = o3;
        bus.in_1         = a;
        bus.in_2         = b;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(2'b10, 2'b00, 1'b0, 32'd1, 32'd2);
        #2;
        checks++;
        if (bus.out_result !== 32'h0 || bus.out_slt !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: result=%h slt=%b want 00000000/0",
                     bus.out_result, bus.out_slt);
        end
        step();
        checks++;
        if (bus.out_result !== 32'h0 || bus.out_slt !== 1'b0) begin
            failures++;
            $display("FAIL reset_held: result=%h slt=%b want 00000000/0",
                     bus.out_result, bus.out_slt);
        end
        reset = 1'b0;
    endtask

    task automatic test_logic;
        logic [31:0] exp [4];
        exp = '{32'd143, 32'd255, 32'hFFFFFF00, 32'h00000070};
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, i[1:0], 1'b0, 32'd255, 32'd143);
            step();
            checks++;
            if (bus.out_result !== exp[i] || bus.out_slt !== 1'b0) begin
                failures++;
                $display("FAIL logic op2=%0d: result=%h slt=%b want %h/0",
                         i, bus.out_result, bus.out_slt, exp[i]);
            end
        end
    endtask

    task automatic test_arith;
        logic [1:0]  op2 [4];
        logic [31:0] a   [4];
        logic [31:0] b   [4];
        logic [31:0] exp [4];
        op2 = '{2'b00, 2'b10, 2'b01, 2'b11};
        a   = '{32'd13, 32'd3000000000, 32'd50, 32'd25};
        b   = '{32'd19, 32'd4000000000, 32'd25, 32'd50};
        exp = '{32'd32, 32'hA13B8600, 32'd25, 32'hFFFFFFE7};
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, op2[i], 1'b0, a[i], b[i]);
            step();
            checks++;
            if (bus.out_result !== exp[i] || bus.out_slt !== 1'b0) begin
                failures++;
                $display("FAIL arith #%0d: result=%h slt=%b want %h/0",
                         i, bus.out_result, bus.out_slt, exp[i]);
            end
        end
    endtask

    task automatic test_slt;
        logic [31:0] a   [4];
        logic [31:0] b   [4];
        logic        exp [4];
        a   = '{32'd25, 32'd50, 32'h00000001, 32'h80000000};
        b   = '{32'd50, 32'd25, 32'hFFFFFFFF, 32'h7FFFFFFF};
        exp = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 2'(i), 1'(i), a[i], b[i]);
            step();
            checks++;
            if (bus.out_slt !== exp[i] ||
                bus.out_result !== {31'b0, exp[i]}) begin
                failures++;
                $display("FAIL slt #%0d: result=%h slt=%b want slt=%b",
                         i, bus.out_result, bus.out_slt, exp[i]);
            end
        end
    endtask

    task automatic test_shift_sweep;
        logic [1:0]  op2 [6];
        logic        dir [6];
        logic [31:0] exp [6][6];
        op2 = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
        dir = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp[0] = '{32'hF800007C, 32'hF00000F8, 32'hE00001F0,
                   32'hC00003E0, 32'h800007C0, 32'h00000F80};
        exp[1] = '{32'hF800007C, 32'h7C00003E, 32'h3E00001F,
                   32'h1F00000F, 32'h0F800007, 32'h07C00003};
        exp[2] = '{32'hF800007C, 32'hF00000F9, 32'hE00001F3,
                   32'hC00003E7, 32'h800007CF, 32'h00000F9F};
        exp[3] = '{32'hF800007C, 32'h7C00003E, 32'h3E00001F,
                   32'h9F00000F, 32'hCF800007, 32'hE7C00003};
        exp[4] = '{32'hF800007C, 32'hFC00003E, 32'hFE00001F,
                   32'hFF00000F, 32'hFF800007, 32'hFFC00003};
        exp[5] = exp[0];
        for (int t = 0; t < 6; t++) begin
            for (int n = 0; n < 6; n++) begin
                drive(2'b00, op2[t], dir[t], 32'hF800007C, 32'(n));
                step();
                checks++;
                if (bus.out_result !== exp[t][n] || bus.out_slt !== 1'b0) begin
                    failures++;
                    $display("FAIL shift t=%0d n=%0d: result=%h want %h",
                             t, n, bus.out_result, exp[t][n]);
                end
            end
        end
    endtask

    task automatic test_shift_edges;
        drive(2'b00, 2'b00, 1'b1, 32'hF800007C, 32'd36);
        step();
        checks++;
        if (bus.out_result !== 32'h0F800007) begin
            failures++;
            $display("FAIL srl_amt36: result=%h want 0F800007", bus.out_result);
        end
        drive(2'b00, 2'b01, 1'b0, 32'hF800007C, 32'd36);
        step();
        checks++;
        if (bus.out_result !== 32'h800007CF) begin
            failures++;
            $display("FAIL rol_amt36: result=%h want 800007CF", bus.out_result);
        end
        drive(2'b00, 2'b11, 1'b1, 32'hF800007C, 32'd4);
        step();
        checks++;
        if (bus.out_result !== 32'h0F800007) begin
            failures++;
            $display("FAIL op2_11_right: result=%h want 0F800007",
                     bus.out_result);
        end
        drive(2'b00, 2'b11, 1'b0, 32'hF800007C, 32'd4);
        step();
        checks++;
        if (bus.out_result !== 32'h800007C0) begin
            failures++;
            $display("FAIL op2_11_left: result=%h want 800007C0",
                     bus.out_result);
        end
        drive(2'b00, 2'b10, 1'b0, 32'h7800007C, 32'd1);
        step();
        checks++;
        if (bus.out_result !== 32'hF00000F8) begin
            failures++;
            $display("FAIL sla_pos: result=%h want F00000F8", bus.out_result);
        end
    endtask

    task automatic test_hold;
        drive(2'b11, 2'b11, 1'b0, 32'h12345678, 32'hFFFF0000);
        step();
        drive(2'b10, 2'b00, 1'b0, 32'd7, 32'd8);
        #3;
        checks++;
        if (bus.out_result !== 32'hEDCB5678) begin
            failures++;
            $display("FAIL hold_between_edges: result=%h want EDCB5678",
                     bus.out_result);
        end
        step();
        checks++;
        if (bus.out_result !== 32'd15) begin
            failures++;
            $display("FAIL hold_next_edge: result=%h want 0000000F",
                     bus.out_result);
        end
    endtask

    task automatic test_reset_midstream;
        drive(2'b01, 2'b00, 1'b0, 32'd50, 32'd25);
        step();
        drive(2'b10, 2'b00, 1'b0, 32'd13, 32'd19);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.out_result !== 32'h0 || bus.out_slt !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: result=%h slt=%b want 0/0",
                     bus.out_result, bus.out_slt);
        end
        step();
        checks++;
        if (bus.out_result !== 32'h0 || bus.out_slt !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_discard: result=%h slt=%b want 0/0",
                     bus.out_result, bus.out_slt);
        end
        drive(2'b10, 2'b01, 1'b0, 32'd50, 32'd25);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_result !== 32'h0) begin
            failures++;
            $display("FAIL reset_release_wait: result=%h want 0",
                     bus.out_result);
        end
        step();
        checks++;
        if (bus.out_result !== 32'd25 || bus.out_slt !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_capture: result=%h want 00000019",
                     bus.out_result);
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_arith();
        test_slt();
        test_shift_sweep();
        test_shift_edges();
        test_hold();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
